// File: rtl/regs_bank.sv
// regs_bank: register bank between the byte-stream command decoder and the
// board-control I/O.
//
//   Status channels 0..N_RD-1 (read-only): status_in is synchronised through
//   two flops. A request on valid_bus[i] captures a snapshot of the
//   synchronised value and raises have_msg_bus[i]. The snapshot is held until
//   the reply formatter acknowledges it on rdreq_bus[i].
//
//   Control channels N_RD..N_RD+N_WR-1 (read/write): a strobe on
//   valid_bus[N_RD+k] loads master_data into control k. Each control can
//   optionally act as a self-clearing pulse (PULSE_MASK) and can optionally
//   post its new value back as a message (ECHO_EN_MASK).
//
// Ports
//   clk           system clock
//   n_rst         asynchronous active-low reset
//   master_data   write data from the decoder (ignored by status channels)
//   valid_bus     per-channel request/write strobe
//   rdreq_bus     per-channel read acknowledge
//   have_msg_bus  per-channel pending-message flags
//   len           reply length, always 1
//   slave_data    data of the lowest-index pending channel, 0 if none
//   status_in     raw asynchronous status inputs, slice i = channel i
//   ctrl_out      registered control outputs, slice k = control k
//
// Build option
//   REGS_BANK_CHANGE_NOTIFY_EN: when defined, any change on a synchronised
//   status channel posts an unsolicited snapshot message.

module regs_bank_ctrl #(
    parameter int              W         = 8,
    parameter logic [W-1:0]    RST       = '0,
    parameter bit              PULSE     = 1'b0,
    parameter logic [7:0]      PLEN      = 8'd4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         wr,
    input  logic [W-1:0] data,
    output logic [W-1:0] q
);
    // cnt stays 0 for non-pulse controls, so the expiry branch never fires.
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q   <= RST;
            cnt <= '0;
        end else if (wr) begin
            q <= data;
            if (PULSE) cnt <= PLEN;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
            // Last counted cycle: value has been visible for PLEN cycles.
            if (cnt == 8'd1) q <= RST;
        end
    end
endmodule

module regs_bank #(
    parameter int                N_RD         = 4,
    parameter int                N_WR         = 23,
    parameter int                W            = 8,
    parameter logic [N_WR*W-1:0] RST_VAL      = '0,
    parameter logic [N_WR-1:0]   PULSE_MASK   = '0,
    parameter int                PULSE_LEN    = 4,
    parameter logic [N_WR-1:0]   ECHO_EN_MASK = '0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [W-1:0]         master_data,
    input  logic [N_RD+N_WR-1:0] valid_bus,
    input  logic [N_RD+N_WR-1:0] rdreq_bus,
    output logic [N_RD+N_WR-1:0] have_msg_bus,
    output logic [7:0]           len,
    output logic [W-1:0]         slave_data,
    input  logic [N_RD*W-1:0]    status_in,
    output logic [N_WR*W-1:0]    ctrl_out
);
    localparam int         N    = N_RD + N_WR;
    localparam logic [7:0] PLEN = 8'(PULSE_LEN);

    logic [N_RD-1:0][W-1:0] s1, s2, snap;
    logic [N_WR-1:0][W-1:0] ctrl;
    logic [N-1:0]           pending, pending_nxt, set_bus;
    logic [N_RD-1:0]        chg;

`ifdef REGS_BANK_CHANGE_NOTIFY_EN
    logic [N_RD-1:0][W-1:0] s2_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) s2_q <= '0;
        else        s2_q <= s2;
    end

    always_comb begin
        chg = '0;
        for (int i = 0; i < N_RD; i++) chg[i] = (s2[i] != s2_q[i]);
    end
`else
    assign chg = '0;
`endif

    // Status channels always post on request; controls only when echo is on.
    // A new post wins over an acknowledge in the same cycle.
    always_comb begin
        set_bus     = (valid_bus & {ECHO_EN_MASK, {N_RD{1'b1}}}) | {{N_WR{1'b0}}, chg};
        pending_nxt = set_bus | (pending & ~rdreq_bus);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1      <= '0;
            s2      <= '0;
            snap    <= '0;
            pending <= '0;
        end else begin
            s1      <= status_in;
            s2      <= s1;
            pending <= pending_nxt;
            for (int i = 0; i < N_RD; i++)
                if (valid_bus[i] || chg[i]) snap[i] <= s2[i];
        end
    end

    for (genvar k = 0; k < N_WR; k++) begin : g_ctrl
        regs_bank_ctrl #(
            .W     (W),
            .RST   (RST_VAL[k*W +: W]),
            .PULSE (PULSE_MASK[k]),
            .PLEN  (PLEN)
        ) u_ctrl (
            .clk   (clk),
            .n_rst (n_rst),
            .wr    (valid_bus[N_RD+k]),
            .data  (master_data),
            .q     (ctrl[k])
        );
    end

    // Lowest-index pending channel wins: scan from the top so the last hit sticks.
    always_comb begin
        slave_data = '0;
        for (int c = N_WR - 1; c >= 0; c--)
            if (pending[N_RD+c]) slave_data = ctrl[c];
        for (int i = N_RD - 1; i >= 0; i--)
            if (pending[i]) slave_data = snap[i];
    end

    assign have_msg_bus = pending;
    assign ctrl_out     = ctrl;
    assign len          = 8'd1;
endmodule

// File: tb/tb_regs_bank.sv
// Self-checking bench for regs_bank: directed scenarios from the test plan plus
// a randomized run, all checked against a behavioural model that works from
// input history and write timestamps.
module tb_regs_bank;
    localparam int NR = 4;
    localparam int NW = 23;
    localparam int W  = 8;
    localparam int N  = NR + NW;
    localparam int L  = 4;
    localparam logic [NW*W-1:0] RSTV  = {{(NW-2)*W{1'b0}}, 8'h01, 8'h7F};
    localparam logic [NW-1:0]   PMASK = 23'h1;
    localparam logic [NW-1:0]   EMASK = 23'h8;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [W-1:0]    master_data;
    logic [N-1:0]    valid_bus, rdreq_bus, have_msg_bus;
    logic [7:0]      len;
    logic [W-1:0]    slave_data;
    logic [NR*W-1:0] status_in;
    logic [NW*W-1:0] ctrl_out;

    int total = 0;
    int bad   = 0;

    regs_bank #(
        .N_RD(NR), .N_WR(NW), .W(W), .RST_VAL(RSTV), .PULSE_MASK(PMASK),
        .PULSE_LEN(L), .ECHO_EN_MASK(EMASK)
    ) dut (
        .clk(clk), .n_rst(n_rst), .master_data(master_data),
        .valid_bus(valid_bus), .rdreq_bus(rdreq_bus), .have_msg_bus(have_msg_bus),
        .len(len), .slave_data(slave_data), .status_in(status_in), .ctrl_out(ctrl_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [NW*W-1:0] rstv  = RSTV;
    logic [NW-1:0]   pmask = PMASK;
    logic [NW-1:0]   emask = EMASK;
    bit              notify;
    int              cyc;                 // edges since reset release
    logic [NR*W-1:0] hist[$];             // status_in sampled at each edge
    logic [W-1:0]    m_snap[NR];
    logic [N-1:0]    m_pend;
    logic [W-1:0]    m_wdata[NW];
    int              m_wcyc[NW];
    bit              m_wr[NW];

    function automatic void model_reset();
        cyc = 0;
        hist.delete();
        m_pend = '0;
        for (int i = 0; i < NR; i++) m_snap[i] = '0;
        for (int k = 0; k < NW; k++) begin m_wr[k] = 0; m_wcyc[k] = 0; m_wdata[k] = '0; end
    endfunction

    // Synchronised status seen 'off' edges back (2 = current, 3 = previous).
    function automatic logic [NR*W-1:0] sync_at(int off);
        if (hist.size() >= off) return hist[hist.size() - off];
        return '0;
    endfunction

    function automatic logic [W-1:0] ctrl_val(int k);
        if (!m_wr[k]) return rstv[k*W +: W];
        if (pmask[k] && (cyc - 1 - m_wcyc[k]) >= L) return rstv[k*W +: W];
        return m_wdata[k];
    endfunction

    function automatic logic [NW*W-1:0] exp_ctrl();
        logic [NW*W-1:0] v;
        for (int k = 0; k < NW; k++) v[k*W +: W] = ctrl_val(k);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_slave();
        for (int c = 0; c < N; c++)
            if (m_pend[c]) return (c < NR) ? m_snap[c] : ctrl_val(c - NR);
        return '0;
    endfunction

    function automatic void model_edge();
        logic [NR*W-1:0] cur = sync_at(2);
        logic [NR*W-1:0] prv = sync_at(3);
        for (int i = 0; i < NR; i++) begin
            bit chg = notify && (cur[i*W +: W] != prv[i*W +: W]);
            if (valid_bus[i] || chg) begin m_snap[i] = cur[i*W +: W]; m_pend[i] = 1'b1; end
            else if (rdreq_bus[i]) m_pend[i] = 1'b0;
        end
        for (int k = 0; k < NW; k++) begin
            if (valid_bus[NR+k]) begin
                m_wdata[k] = master_data; m_wcyc[k] = cyc; m_wr[k] = 1;
                if (emask[k]) m_pend[NR+k] = 1'b1;
            end else if (rdreq_bus[NR+k]) m_pend[NR+k] = 1'b0;
        end
        hist.push_back(status_in);
        if (hist.size() > 4) void'(hist.pop_front());
        cyc++;
    endfunction

    task automatic step();
        @(posedge clk);
        if (n_rst) model_edge();
        #1;
    endtask

    task automatic idle(int n);
        valid_bus = '0; rdreq_bus = '0;
        repeat (n) step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_rst = 1'b0; master_data = '0; valid_bus = '0; rdreq_bus = '0; status_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (ctrl_out !== RSTV) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", ctrl_out, RSTV); end
        total++; if (have_msg_bus !== '0) begin bad++; $display("FAIL reset_msg got=%h exp=0", have_msg_bus); end
        total++; if (len !== 8'd1) begin bad++; $display("FAIL reset_len got=%0d exp=1", len); end
        total++; if (slave_data !== '0) begin bad++; $display("FAIL reset_slave got=%h exp=0", slave_data); end
        n_rst = 1'b1;
        idle(2);
        // write controls 0, 1 and echo control 3, then reset mid-pulse
        valid_bus[NR+0] = 1'b1; valid_bus[NR+1] = 1'b1; valid_bus[NR+3] = 1'b1; master_data = 8'hAA;
        step();
        valid_bus = '0;
        total++; if (ctrl_out[15:0] !== 16'hAAAA) begin bad++; $display("FAIL pre_reset_ctrl got=%h exp=aaaa", ctrl_out[15:0]); end
        #2 n_rst = 1'b0; model_reset();
        #1;
        total++; if (ctrl_out[15:0] !== 16'h017F) begin bad++; $display("FAIL midrun_reset_ctrl got=%h exp=017f", ctrl_out[15:0]); end
        total++; if (have_msg_bus !== '0) begin bad++; $display("FAIL midrun_reset_msg got=%h exp=0", have_msg_bus); end
        total++; if (len !== 8'd1) begin bad++; $display("FAIL midrun_reset_len got=%0d exp=1", len); end
        @(posedge clk); #1 n_rst = 1'b1;
        idle(4);
        total++; if (ctrl_out !== RSTV) begin bad++; $display("FAIL post_reset_ctrl got=%h exp=%h", ctrl_out, RSTV); end
    endtask

    task automatic test_status_req();
        status_in[7:0] = 8'hA5;
        idle(3);
        rdreq_bus[0] = 1'b1; step(); rdreq_bus = '0;   // drop any unsolicited report
        valid_bus[0] = 1'b1; step(); valid_bus = '0;
        total++; if (have_msg_bus[0] !== 1'b1) begin bad++; $display("FAIL status_flag got=%b exp=1", have_msg_bus[0]); end
        total++; if (slave_data !== 8'hA5) begin bad++; $display("FAIL status_data got=%h exp=a5", slave_data); end
        status_in[7:0] = 8'h3C;
        idle(3);
        total++; if (slave_data !== exp_slave()) begin bad++; $display("FAIL status_hold got=%h exp=%h", slave_data, exp_slave()); end
        rdreq_bus[0] = 1'b1; step(); rdreq_bus = '0;
        total++; if (have_msg_bus[0] !== m_pend[0]) begin bad++; $display("FAIL status_ack got=%b exp=%b", have_msg_bus[0], m_pend[0]); end
        idle(3);
        rdreq_bus[0] = 1'b1; step(); rdreq_bus = '0;
        total++; if (have_msg_bus !== '0) begin bad++; $display("FAIL status_clear got=%h exp=0", have_msg_bus); end
    endtask

    task automatic test_priority();
        status_in[15:8] = 8'h11; status_in[23:16] = 8'h22;
        idle(3);
        rdreq_bus[2:1] = 2'b11; step(); rdreq_bus = '0;
        valid_bus[2:1] = 2'b11; step(); valid_bus = '0;
        total++; if (slave_data !== 8'h11) begin bad++; $display("FAIL prio_ch1 got=%h exp=11", slave_data); end
        status_in[15:8] = 8'h33;
        idle(3);
        rdreq_bus[1] = 1'b1; valid_bus[1] = 1'b1; step(); valid_bus = '0; rdreq_bus = '0;
        total++; if (have_msg_bus[1] !== 1'b1) begin bad++; $display("FAIL collide_flag got=%b exp=1", have_msg_bus[1]); end
        total++; if (slave_data !== 8'h33) begin bad++; $display("FAIL collide_data got=%h exp=33", slave_data); end
        rdreq_bus[1] = 1'b1; step(); rdreq_bus = '0;
        total++; if (slave_data !== exp_slave() || have_msg_bus !== m_pend) begin
            bad++; $display("FAIL prio_ch2 got=%h/%h exp=%h/%h", slave_data, have_msg_bus, exp_slave(), m_pend); end
        rdreq_bus[2] = 1'b1; step(); rdreq_bus = '0;
        total++; if (have_msg_bus !== m_pend) begin bad++; $display("FAIL prio_done got=%h exp=%h", have_msg_bus, m_pend); end
    endtask

    task automatic test_pulse();
        valid_bus[NR] = 1'b1; master_data = 8'h01; step(); valid_bus = '0;
        for (int c = 0; c < 6; c++) begin
            logic [7:0] e = (c < L) ? 8'h01 : 8'h7F;
            total++; if (ctrl_out[7:0] !== e) begin bad++; $display("FAIL pulse c=%0d got=%h exp=%h", c, ctrl_out[7:0], e); end
            step();
        end
        valid_bus[NR] = 1'b1; step(); valid_bus = '0;
        step();
        valid_bus[NR] = 1'b1; step(); valid_bus = '0;   // rewrite two cycles in
        for (int c = 0; c < 6; c++) begin
            logic [7:0] e = (c < L) ? 8'h01 : 8'h7F;
            total++; if (ctrl_out[7:0] !== e) begin bad++; $display("FAIL repulse c=%0d got=%h exp=%h", c, ctrl_out[7:0], e); end
            total++; if (ctrl_out !== exp_ctrl()) begin bad++; $display("FAIL repulse_model c=%0d got=%h exp=%h", c, ctrl_out, exp_ctrl()); end
            step();
        end
    endtask

    task automatic test_echo();
        valid_bus[NR+3] = 1'b1; master_data = 8'h5A; step(); valid_bus = '0;
        total++; if (have_msg_bus[NR+3] !== 1'b1) begin bad++; $display("FAIL echo_flag got=%b exp=1", have_msg_bus[NR+3]); end
        total++; if (slave_data !== 8'h5A) begin bad++; $display("FAIL echo_data got=%h exp=5a", slave_data); end
        valid_bus[NR+4] = 1'b1; master_data = 8'h77; step(); valid_bus = '0;
        total++; if (have_msg_bus[NR+4] !== 1'b0) begin bad++; $display("FAIL noecho_flag got=%b exp=0", have_msg_bus[NR+4]); end
        total++; if (ctrl_out[4*W +: W] !== 8'h77) begin bad++; $display("FAIL noecho_ctrl got=%h exp=77", ctrl_out[4*W +: W]); end
        rdreq_bus[NR+3] = 1'b1; step(); rdreq_bus = '0;
        total++; if (have_msg_bus[NR+3] !== 1'b0) begin bad++; $display("FAIL echo_ack got=%b exp=0", have_msg_bus[NR+3]); end
    endtask

    task automatic test_change_notify();
        logic exp3 = notify;
        idle(4);
        rdreq_bus = '1; step(); rdreq_bus = '0;
        status_in[8] = ~status_in[8];
        for (int c = 1; c <= 4; c++) begin
            step();
            total++; if (have_msg_bus[1] !== m_pend[1]) begin bad++; $display("FAIL notify c=%0d got=%b exp=%b", c, have_msg_bus[1], m_pend[1]); end
            if (c == 3) begin
                total++; if (have_msg_bus[1] !== exp3) begin bad++; $display("FAIL notify_at3 got=%b exp=%b", have_msg_bus[1], exp3); end
            end
        end
        rdreq_bus = '1; step(); rdreq_bus = '0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            for (int b = 0; b < N; b++) begin
                valid_bus[b] = ($urandom_range(0, 15) == 0);
                rdreq_bus[b] = ($urandom_range(0, 3) == 0);
            end
            master_data = 8'($urandom);
            if ($urandom_range(0, 3) == 0) status_in = $urandom;
            step();
            total++; if (have_msg_bus !== m_pend) begin bad++; $display("FAIL rnd_msg t=%0d got=%h exp=%h", t, have_msg_bus, m_pend); end
            total++; if (slave_data !== exp_slave()) begin bad++; $display("FAIL rnd_slave t=%0d got=%h exp=%h", t, slave_data, exp_slave()); end
            total++; if (ctrl_out !== exp_ctrl()) begin bad++; $display("FAIL rnd_ctrl t=%0d got=%h exp=%h", t, ctrl_out, exp_ctrl()); end
            total++; if (len !== 8'd1) begin bad++; $display("FAIL rnd_len t=%0d got=%0d exp=1", t, len); end
            if (t == 200) begin
                #2 n_rst = 1'b0; model_reset();
                #1;
                total++; if (ctrl_out !== RSTV || have_msg_bus !== '0) begin
                    bad++; $display("FAIL rnd_reset got=%h/%h exp=%h/0", ctrl_out, have_msg_bus, RSTV); end
                @(posedge clk); #1 n_rst = 1'b1;
            end
        end
    endtask

    initial begin
`ifdef REGS_BANK_CHANGE_NOTIFY_EN
        notify = 1'b1;
`else
        notify = 1'b0;
`endif
        test_reset();
        test_status_req();
        test_priority();
        test_pulse();
        test_echo();
        test_change_notify();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
